// File: rtl/tdr_pkg.sv
// Shared types and default widths for the time-domain register ring readout.
package tdr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    COUNT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } tdr_rd_state_t;

  localparam int TDR_CNT_W = 8;
  localparam int TDR_WIN_W = 10;

endpackage

// File: rtl/tdr_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, followed by a rising-edge detector.
module tdr_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_i};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign sync_o = r_sync[SYNC_STAGES-1];
  assign rise_o = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/tdr_ring_reader.sv
// Gated ring oscillator readout: runs the ring for a programmed window and
// counts its rising edges in the clk domain, saturating with a sticky overflow.
module tdr_ring_reader
  import tdr_pkg::*;
#(
  parameter int CNT_W       = TDR_CNT_W,
  parameter int WIN_W       = TDR_WIN_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIN_W-1:0] window_i,
  input  logic             ring_i,
  output logic             ring_tsc_o,
  output logic             ring_re_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o
);

  localparam int               PH_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(SYNC_STAGES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  tdr_rd_state_t    r_state;
  logic [WIN_W-1:0] r_win;
  logic [PH_W-1:0]  r_phase;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_tsc;
  logic             r_re;
  logic             r_busy;
  logic             r_valid;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf_o;

  logic w_sync;
  logic w_rise;

  tdr_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .async_i(ring_i),
    .sync_o (w_sync),
    .rise_o (w_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_win   <= '0;
      r_phase <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_tsc   <= 1'b0;
      r_re    <= 1'b1;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_count <= '0;
      r_ovf_o <= 1'b0;
    end else begin
      r_valid <= 1'b0;

      // Edges seen in ARM are stale synchronizer contents; DRAIN catches edges still in flight.
      if ((r_state == COUNT || r_state == DRAIN) && w_rise && w_sync) begin
        if (r_cnt == CNT_MAX) begin
          r_ovf <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_win   <= (window_i == '0) ? WIN_ONE : window_i;
            r_phase <= PH_LAST;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_tsc   <= 1'b1;
            r_re    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ARM;
          end
        end
        ARM: begin
          if (r_phase == '0) begin
            r_state <= COUNT;
          end else begin
            r_phase <= r_phase - 1'b1;
          end
        end
        COUNT: begin
          if (r_win == WIN_ONE) begin
            r_phase <= PH_LAST;
            r_tsc   <= 1'b0;
            r_re    <= 1'b1;
            r_state <= DRAIN;
          end else begin
            r_win <= r_win - 1'b1;
          end
        end
        DRAIN: begin
          if (r_phase == '0) begin
            r_busy  <= 1'b0;
            r_state <= DONE;
          end else begin
            r_phase <= r_phase - 1'b1;
          end
        end
        DONE: begin
          r_count <= r_cnt;
          r_ovf_o <= r_ovf;
          r_valid <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_tsc   <= 1'b0;
          r_re    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ring_tsc_o = r_tsc;
  assign ring_re_o  = r_re;
  assign busy_o     = r_busy;
  assign valid_o    = r_valid;
  assign count_o    = r_count;
  assign ovf_o      = r_ovf_o;

endmodule

// File: tb/tb_tdr_ring_reader.sv
// Directed self-checking bench for tdr_ring_reader with a clock-divided ring model.
module tb_tdr_ring_reader;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [9:0] window_i;
  logic       ring_i;
  logic       ring_tsc_o;
  logic       ring_re_o;
  logic       busy_o;
  logic       valid_o;
  logic [7:0] count_o;
  logic       ovf_o;

  int errors = 0;
  int checks = 0;
  int ring_half = 2;
  int ring_div;

  tdr_ring_reader #(
    .CNT_W(8),
    .WIN_W(10),
    .SYNC_STAGES(S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .window_i  (window_i),
    .ring_i    (ring_i),
    .ring_tsc_o(ring_tsc_o),
    .ring_re_o (ring_re_o),
    .busy_o    (busy_o),
    .valid_o   (valid_o),
    .count_o   (count_o),
    .ovf_o     (ovf_o)
  );

  always #5 clk = ~clk;

  // Ring model: toggles every ring_half clocks while enabled, holds level when frozen.
  always @(negedge clk) begin
    if (rst) begin
      ring_i   <= 1'b0;
      ring_div <= 0;
    end else if (ring_tsc_o) begin
      if (ring_div >= ring_half - 1) begin
        ring_i   <= ~ring_i;
        ring_div <= 0;
      end else begin
        ring_div <= ring_div + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("complement", ring_tsc_o, !ring_re_o);
    if (!busy_o) chk("tsc_idle", ring_tsc_o, 0);
  endtask

  task automatic run_measure(input int win, input int poke_k, input int half);
    int w;
    int lat;
    logic [31:0] exp_tsc;
    logic [31:0] exp_busy;
    w   = (win == 0) ? 1 : win;
    lat = 1 + 2 * S + w;
    ring_half = half;
    @(negedge clk);
    start_i  = 1'b1;
    window_i = win[9:0];
    @(posedge clk);
    #1;
    start_i = 1'b0;
    for (int k = 0; k < lat; k++) begin
      exp_tsc  = (k < S + w) ? 1 : 0;
      exp_busy = (k < 2 * S + w) ? 1 : 0;
      chk("tsc_phase", ring_tsc_o, exp_tsc);
      chk("busy_phase", busy_o, exp_busy);
      chk("valid_early", valid_o, 0);
      start_i = (k == poke_k) ? 1'b1 : 1'b0;
      tick();
    end
    start_i = 1'b0;
    chk("valid_pulse", valid_o, 1);
    chk("busy_done", busy_o, 0);
  endtask

  initial begin
    int held;
    int extra;
    int win;
    int half;

    rst      = 1'b1;
    start_i  = 1'b0;
    window_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      tick();
      chk("rst_re", ring_re_o, 1);
      chk("rst_tsc", ring_tsc_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_count", count_o, 0);
    end

    // Basic window of 40 with a ring period of 4 clocks: about 10 rising edges.
    run_measure(40, -1, 2);
    chk("basic_count_range", (count_o >= 8'd9 && count_o <= 8'd11) ? 1 : 0, 1);
    chk("basic_ovf", ovf_o, 0);
    held = count_o;
    repeat (5) tick();
    chk("count_hold", count_o, held);
    chk("valid_single", valid_o, 0);

    run_measure(0, -1, 2);
    chk("win0_count_le1", (count_o <= 8'd1) ? 1 : 0, 1);

    // Saturation: one rising edge every 2 clocks over 600 cycles.
    run_measure(600, -1, 1);
    chk("sat_count", count_o, 255);
    chk("sat_ovf", ovf_o, 1);
    run_measure(8, -1, 1);
    chk("ovf_cleared", ovf_o, 0);
    chk("short_count_range", (count_o >= 8'd3 && count_o <= 8'd6) ? 1 : 0, 1);

    // Start pulsed mid-COUNT, then a start presented during DONE.
    run_measure(20, 8, 2);
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (valid_o || busy_o) extra++;
    end
    chk("mid_start_ignored", extra, 0);
    run_measure(10, 2 * S + 10, 2);
    tick();
    chk("done_start_ignored", busy_o, 0);

    // Abort with reset during COUNT.
    @(negedge clk);
    start_i  = 1'b1;
    window_i = 10'd100;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (10) tick();
    chk("abort_pre_tsc", ring_tsc_o, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_re", ring_re_o, 1);
    chk("abort_tsc", ring_tsc_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_valid", valid_o, 0);
    chk("abort_count", count_o, 0);
    chk("abort_ovf", ovf_o, 0);
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (valid_o || busy_o) extra++;
    end
    chk("abort_no_valid", extra, 0);

    for (int i = 0; i < 8; i++) begin
      win  = $urandom_range(0, 40);
      half = $urandom_range(1, 3);
      run_measure(win, -1, half);
      chk("rand_ovf", ovf_o, 0);
      repeat (2) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
